fetch_pc_gen: RTL and testbench
===============================

// Module: fetch_pc_gen
// PURPOSE
//   Next-PC generator for the fetch stage. Drives the current fetch PC into the branch target buffer and instruction memory.
//   Consumes the buffer's same-cycle prediction (valid / taken / target) to select the next PC.
//   Registers a fetch packet {pc, prediction} toward decode, with stall back-pressure and execute-stage redirect.
// PARAMETERS
//   RESET_PC   32'h0000_0000   fetch address loaded on reset
//   PERF_W     32              width of each perf counter (used only with FETCH_PERF_CNT_EN)
// PORTS
//   clk             in   1    single clock, all state on posedge
//   rst             in   1    synchronous, active-high reset
//   stall           in   1    decode cannot accept; hold PC and packet
//   redirect        in   1    execute resolved a mispredict; restart at redirect_pc
//   redirect_pc     in   32   corrected fetch address
//   btb_valid       in   1    BTB hit for current pc
//   btb_taken       in   1    BTB predicts taken
//   btb_target      in   32   BTB predicted target
//   pc              out  32   current fetch PC (to BTB pc input and imem address)
//   fetch_valid     out  1    pc is a real fetch this cycle
//   if_valid        out  1    fetch packet valid toward decode
//   if_pc           out  32   PC of fetch packet
//   if_pred_taken   out  1    prediction carried with packet (btb_valid & btb_taken)
//   if_pred_target  out  32   predicted target carried with packet
//   perf_fetch_cnt / perf_pred_cnt / perf_redir_cnt   out  PERF_W   counters (see CONFIGURATION)
// BEHAVIOUR
//   - Sync active-high reset: rst sampled at posedge only.
//   - Reset values: pc=RESET_PC, state=S_BOOT, fetch_valid=0, if_valid=0, if_pc=0, if_pred_taken=0, if_pred_target=0, counters=0.
//   - FSM, 2 states:
//     - S_BOOT (fetch_valid=0): next cycle -> S_RUN, pc unchanged (or redirect_pc if redirect=1).
//     - S_RUN (fetch_valid=1): stays in S_RUN until rst.
//   - Next-pc priority each posedge: rst > redirect > stall > (btb_valid&btb_taken ? btb_target : pc+4).
//   - Redirect: pc <= {redirect_pc[31:2],2'b00}; if_valid <= 0 (flushes in-flight packet). Applies in any state and overrides stall.
//   - Stall (no redirect): pc and all if_* registers hold; BTB sees same pc again.
//   - Normal advance (no stall, no redirect):
//     - if_valid <= fetch_valid; if_pc <= pc;
//     - if_pred_taken <= btb_valid&btb_taken; if_pred_target <= btb_target.
//     - Prediction is used only if btb_valid; if_pred_target is don't-care when if_pred_taken=0.
//   - Alignment: btb_target and redirect_pc bits [1:0] forced to 0 before loading pc.
//   - Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
//   - Latency: pc -> if_* packet is 1 cycle; a redirect produces exactly 1 bubble (if_valid=0) before the packet at redirect_pc.
//   - rst asserted mid-operation: everything returns to reset values next posedge, regardless of stall/redirect.
// CONFIGURATION
//   - `FETCH_PERF_CNT_EN defined: three saturating PERF_W counters, cleared by rst:
//     - perf_fetch_cnt: +1 per advancing cycle with fetch_valid=1.
//     - perf_pred_cnt: +1 per advancing cycle with fetch_valid & btb_valid & btb_taken.
//     - perf_redir_cnt: +1 per cycle with redirect=1.
//     - Each holds at all-ones.
//   - Not defined: ports remain, driven constant 0; no counter flops.
// STRUCTURE
//   - Shared package fetch_pkg:
//     - state enum {S_BOOT,S_RUN};
//     - INSN_BYTES=4;
//     - fetch-packet struct {valid,pc,pred_taken,pred_target}.
//   - One sub-module fetch_perf_cnt (saturating counter bank), instantiated only under FETCH_PERF_CNT_EN.
// TESTING
//   - Reset, no hit: rst 1 cycle, btb_valid=0 -> cycle0 fetch_valid=0 pc=0; then pc=0,4,8 and if_pc=0,4 trailing 1 cycle.
//   - BTB taken at pc=0x10, btb_target=0x80 -> next pc=0x80; if_pc=0x10, if_pred_taken=1, if_pred_target=0x80.
//   - Stall 3 cycles at pc=0x20 -> pc and if_* frozen; release -> pc=0x24.
//   - Redirect 0x200 during stall -> next pc=0x200, if_valid=0 one cycle, then if_pc=0x200 valid.
//   - Wrap: redirect_pc=0xFFFF_FFFC, no hit -> next pc=0x0; redirect_pc=0x103 -> pc=0x100.
//   - With FETCH_PERF_CNT_EN, PERF_W=4: 20 advancing fetches -> perf_fetch_cnt saturates at 4'hF; rst -> 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [31:0] INSN_BYTES = 32'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } fetch_pkt_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Bank of three saturating event counters: [0] fetch, [1] predicted-taken, [2] redirect.
module fetch_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [2:0]   inc_i,
  output logic [W-1:0] fetch_cnt_o,
  output logic [W-1:0] pred_cnt_o,
  output logic [W-1:0] redir_cnt_o
);

  logic [2:0][W-1:0] cnt_q;
  logic [2:0][W-1:0] cnt_d;

  // Increment each counter on its event, holding once it reaches all-ones.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (inc_i[i] && (cnt_q[i] != {W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + {{(W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_cnt_o = cnt_q[0];
  assign pred_cnt_o  = cnt_q[1];
  assign redir_cnt_o = cnt_q[2];

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator with BTB-driven prediction, stall and redirect.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              btb_valid,
  input  logic              btb_taken,
  input  logic [31:0]       btb_target,
  output logic [31:0]       pc,
  output logic              fetch_valid,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic              if_pred_taken,
  output logic [31:0]       if_pred_target,
  output logic [PERF_W-1:0] perf_fetch_cnt,
  output logic [PERF_W-1:0] perf_pred_cnt,
  output logic [PERF_W-1:0] perf_redir_cnt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  fetch_pkt_t  pkt_q, pkt_d;
  logic        fetch_valid_s;
  logic        pred_hit_s;

  assign fetch_valid_s = (state_q == S_RUN);
  assign pred_hit_s    = btb_valid & btb_taken;

  // Boot lasts exactly one cycle; afterwards only reset leaves S_RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  // Next PC and packet: redirect beats stall, stall beats normal advance.
  always_comb begin
    pc_d  = pc_q;
    pkt_d = pkt_q;
    if (redirect) begin
      pc_d        = align_pc(redirect_pc);
      pkt_d.valid = 1'b0;
    end else if (stall) begin
      pc_d  = pc_q;
      pkt_d = pkt_q;
    end else begin
      pkt_d.valid       = fetch_valid_s;
      pkt_d.pc          = pc_q;
      pkt_d.pred_taken  = pred_hit_s;
      pkt_d.pred_target = btb_target;
      // The boot cycle issues no fetch, so the PC must not move yet.
      if (!fetch_valid_s) begin
        pc_d = pc_q;
      end else if (pred_hit_s) begin
        pc_d = align_pc(btb_target);
      end else begin
        pc_d = pc_q + INSN_BYTES;
      end
    end
  end

  // State, PC and packet registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pkt_q   <= pkt_d;
    end
  end

  assign pc             = pc_q;
  assign fetch_valid    = fetch_valid_s;
  assign if_valid       = pkt_q.valid;
  assign if_pc          = pkt_q.pc;
  assign if_pred_taken  = pkt_q.pred_taken;
  assign if_pred_target = pkt_q.pred_target;

`ifdef FETCH_PERF_CNT_EN
  logic       advance_s;
  logic [2:0] perf_inc_s;

  assign advance_s  = ~redirect & ~stall;
  assign perf_inc_s = {redirect,
                       advance_s & fetch_valid_s & pred_hit_s,
                       advance_s & fetch_valid_s};

  fetch_perf_cnt #(
    .W (PERF_W)
  ) u_perf (
    .clk_i       (clk),
    .rst_i       (rst),
    .inc_i       (perf_inc_s),
    .fetch_cnt_o (perf_fetch_cnt),
    .pred_cnt_o  (perf_pred_cnt),
    .redir_cnt_o (perf_redir_cnt)
  );
`else
  assign perf_fetch_cnt = '0;
  assign perf_pred_cnt  = '0;
  assign perf_redir_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Randomized + directed bench for fetch_pc_gen against a cycle-level reference model.
module tb_fetch_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        btb_valid;
  logic        btb_taken;
  logic [31:0] btb_target;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic [3:0]  perf_fetch_cnt;
  logic [3:0]  perf_pred_cnt;
  logic [3:0]  perf_redir_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [31:0] m_pc = 32'h0;
  bit          m_booted = 1'b0;
  bit          m_ifv = 1'b0;
  logic [31:0] m_ifpc = 32'h0;
  bit          m_ift = 1'b0;
  logic [31:0] m_iftg = 32'h0;
  logic [3:0]  m_cf = 4'h0;
  logic [3:0]  m_cp = 4'h0;
  logic [3:0]  m_cr = 4'h0;

  fetch_pc_gen #(
    .RESET_PC (32'h0000_0000),
    .PERF_W   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .btb_valid      (btb_valid),
    .btb_taken      (btb_taken),
    .btb_target     (btb_target),
    .pc             (pc),
    .fetch_valid    (fetch_valid),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_pred_cnt  (perf_pred_cnt),
    .perf_redir_cnt (perf_redir_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] sat4(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'h1;
  endfunction

  // Apply one clock edge of the fetch rules to the model, using the inputs currently driven.
  task automatic model_update();
    bit hit;
    hit = btb_valid && btb_taken;
    if (rst) begin
      m_pc = 32'h0; m_booted = 1'b0; m_ifv = 1'b0; m_ifpc = 32'h0;
      m_ift = 1'b0; m_iftg = 32'h0; m_cf = 4'h0; m_cp = 4'h0; m_cr = 4'h0;
    end else begin
      if (redirect) begin
        m_cr  = sat4(m_cr);
        m_pc  = redirect_pc & 32'hFFFF_FFFC;
        m_ifv = 1'b0;
      end else if (!stall) begin
        m_ifv  = m_booted;
        m_ifpc = m_pc;
        m_ift  = hit;
        m_iftg = btb_target;
        if (m_booted) begin
          m_cf = sat4(m_cf);
          if (hit) m_cp = sat4(m_cp);
          m_pc = hit ? (btb_target & 32'hFFFF_FFFC) : m_pc + 32'd4;
        end
      end
      m_booted = 1'b1;
    end
  endtask

  task automatic check_all();
    check_eq("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_booted});
    check_eq("pc", pc, m_pc);
    check_eq("if_valid", {31'd0, if_valid}, {31'd0, m_ifv});
    check_eq("if_pc", if_pc, m_ifpc);
    check_eq("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, m_ift});
    if (m_ift) check_eq("if_pred_target", if_pred_target, m_iftg);
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_fetch", {28'd0, perf_fetch_cnt}, {28'd0, m_cf});
    check_eq("perf_pred", {28'd0, perf_pred_cnt}, {28'd0, m_cp});
    check_eq("perf_redir", {28'd0, perf_redir_cnt}, {28'd0, m_cr});
`else
    check_eq("perf_fetch_off", {28'd0, perf_fetch_cnt}, 32'd0);
    check_eq("perf_pred_off", {28'd0, perf_pred_cnt}, 32'd0);
    check_eq("perf_redir_off", {28'd0, perf_redir_cnt}, 32'd0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    btb_valid = 1'b0; btb_taken = 1'b0; btb_target = 32'h0;
  endtask

  task automatic do_redirect(input logic [31:0] addr, input logic st);
    redirect = 1'b1; redirect_pc = addr; stall = st;
    step();
    redirect = 1'b0; stall = 1'b0;
  endtask

  logic [3:0] exp_sat;

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    check_eq("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_if_pc", if_pc, 32'h0);
    rst = 1'b0;

    // Boot then sequential fetch.
    step();
    check_eq("boot_pc", pc, 32'h0);
    check_eq("boot_fv", {31'd0, fetch_valid}, 32'd1);
    step();
    check_eq("seq_pc4", pc, 32'h4);
    check_eq("seq_ifpc0", if_pc, 32'h0);
    step();
    check_eq("seq_pc8", pc, 32'h8);
    check_eq("seq_ifpc4", if_pc, 32'h4);

    // Taken prediction at 0x10.
    do_redirect(32'h10, 1'b0);
    btb_valid = 1'b1; btb_taken = 1'b1; btb_target = 32'h80;
    step();
    check_eq("btb_pc", pc, 32'h80);
    check_eq("btb_ifpc", if_pc, 32'h10);
    check_eq("btb_taken", {31'd0, if_pred_taken}, 32'd1);
    check_eq("btb_target", if_pred_target, 32'h80);
    idle_inputs();

    // Stall three cycles at 0x20.
    do_redirect(32'h20, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_pc", pc, 32'h20);
    end
    stall = 1'b0;
    step();
    check_eq("unstall_pc", pc, 32'h24);
    check_eq("unstall_ifpc", if_pc, 32'h20);

    // Redirect overriding stall, one bubble then packet at 0x200.
    stall = 1'b1;
    step();
    do_redirect(32'h200, 1'b1);
    check_eq("redir_pc", pc, 32'h200);
    check_eq("redir_bubble", {31'd0, if_valid}, 32'd0);
    step();
    check_eq("redir_ifv", {31'd0, if_valid}, 32'd1);
    check_eq("redir_ifpc", if_pc, 32'h200);

    // Wrap and alignment.
    do_redirect(32'hFFFF_FFFC, 1'b0);
    step();
    check_eq("wrap_pc", pc, 32'h0);
    do_redirect(32'h0000_0103, 1'b0);
    check_eq("align_pc", pc, 32'h100);
    btb_valid = 1'b1; btb_taken = 1'b1; btb_target = 32'h0000_0347;
    step();
    check_eq("btb_align_pc", pc, 32'h344);
    idle_inputs();

    // Counter saturation then reset.
    for (int i = 0; i < 20; i++) step();
`ifdef FETCH_PERF_CNT_EN
    exp_sat = 4'hF;
`else
    exp_sat = 4'h0;
`endif
    check_eq("perf_sat", {28'd0, perf_fetch_cnt}, {28'd0, exp_sat});
    rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    check_eq("midrst_pc", pc, 32'h0);
    check_eq("midrst_perf", {28'd0, perf_fetch_cnt}, 32'd0);
    idle_inputs();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(0, 99) < 2);
      redirect    = ($urandom_range(0, 99) < 8);
      stall       = ($urandom_range(0, 99) < 20);
      redirect_pc = $urandom;
      btb_valid   = $urandom_range(0, 1);
      btb_taken   = $urandom_range(0, 1);
      btb_target  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
